fork_join_ctrl: RTL and testbench
=================================

# fork_join_ctrl

Synthesizable fork/join controller. A parent issues one dispatch request that launches two worker timers in parallel, and the block releases the parent according to a join mode: all workers done, first worker done, or immediately. It sits directly upstream of the worker-task stage, drives its start pulses and consumes its completions. It gives RTL sequencers the fork/join, fork/join_any and fork/join_none semantics the team uses in benches.

## Interface
- `N_TASK`, default 2: number of parallel workers (2..8).
- `DUR_W`, default 8: width of each worker duration, in cycles.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start_valid`  in  1  parent dispatch request; held until accepted.
- `start_ready`  out  1  high only when all workers are idle and no dispatch is pending.
- `join_mode`  in  2  sampled at accept: 0 = JOIN_ALL, 1 = JOIN_ANY, 2 = JOIN_NONE, 3 = reserved (behaves as JOIN_ALL).
- `dur`  in  N_TASK*DUR_W  per-worker durations, slice i = worker i; sampled at accept.
- `task_busy`  out  N_TASK  worker i running.
- `task_done`  out  N_TASK  one-cycle pulse when worker i completes.
- `parent_go`  out  1  one-cycle pulse; parent may proceed.
- `now`  out  16  free-running cycle counter; wraps 0xFFFF→0.

## Operation
- Accept is the cycle in which `start_valid && start_ready` is high; call it cycle 0.
- At accept, latch `join_mode`, load each worker counter with `max(dur_i,1)`, and set every `task_busy` bit from cycle 1.
- Each worker decrements once per cycle from cycle 1.
  - `task_done[i]` pulses in cycle `max(dur_i,1)`.
  - `task_busy[i]` clears in the cycle after that pulse.
- FSM states:
  - IDLE: `start_ready`=1. On accept, go to WAIT (mode ALL/ANY/reserved) or DETACHED (mode NONE).
  - WAIT: parent blocked. In JOIN_ANY, the first cycle with any `task_done` pulses `parent_go` in that same cycle. In JOIN_ALL, the cycle in which the last outstanding worker pulses `task_done` also pulses `parent_go`. After the pulse, go to DETACHED, or straight to IDLE if no worker remains busy.
  - DETACHED: parent released, workers draining. When the last `task_done` pulses, go to IDLE.
- JOIN_NONE: `parent_go` pulses in cycle 1 regardless of durations.
- `start_ready` is low from cycle 1 until the cycle after the last `task_done`, and high again in that following cycle.
- Simultaneous completions:
  - JOIN_ANY with several workers finishing in the same cycle gives exactly one `parent_go`.
  - In JOIN_ALL, equal durations produce all `task_done` pulses and `parent_go` together.
- `start_valid` while `start_ready`=0: the request is ignored and nothing is latched; the requester must hold.
- `now` increments every cycle and is independent of the FSM.

## Timing
- All outputs are registered.
- Reset values: `start_ready`=1, `task_busy`=0, `task_done`=0, `parent_go`=0, `now`=0, FSM in IDLE.
- Reset mid-operation:
  - All counters clear in the cycle after `rst_n` is sampled low.
  - No `task_done` or `parent_go` pulse is produced for the aborted dispatch.
  - `start_ready`=1 in the first cycle after `rst_n` is sampled high.
- Latency from accept:
  - JOIN_NONE `parent_go` = 1 cycle.
  - JOIN_ANY = `min(max(dur_i,1))`.
  - JOIN_ALL = `max(max(dur_i,1))`.
- Minimum re-dispatch interval = longest duration + 1 cycle.

## Structure
- `fork_join_pkg` holds:
  - `join_mode_e` (JOIN_ALL, JOIN_ANY, JOIN_NONE, JOIN_RSVD)
  - `fj_state_e` (IDLE, WAIT, DETACHED)
  - default widths for `DUR_W` and `now`
- Sub-module `task_timer`, instantiated N_TASK times:
  - inputs: load, duration
  - outputs: busy, done pulse
- The top level holds the FSM, the join logic (reduction over done/busy vectors) and the `now` counter.

## Test plan
- JOIN_NONE, dur={20,30}, accept at cycle 0 → `parent_go` in cycle 1; `task_done[0]` in cycle 20; `task_done[1]` in cycle 30; `start_ready` high in cycle 31.
- JOIN_ANY, dur={20,30} → `parent_go` in cycle 20 coincident with `task_done[0]`; FSM DETACHED until cycle 30.
- JOIN_ALL, dur={20,30} → single `parent_go` in cycle 30; none in cycle 20.
- JOIN_ANY, dur={5,5}, then dur={0,3} → first dispatch gives one `parent_go` in cycle 5 with both done bits set; dur=0 completes in cycle 1.
- `start_valid` held during a busy run → no second accept until `start_ready`; then accept proceeds with the durations present at that cycle.
- `rst_n` low at cycle 10 of a JOIN_ALL {20,30} run → all outputs return to reset values and no `task_done` or `parent_go` pulses afterwards; `now` restarts at 0.

Source files
------------

// File: rtl/fork_join_ctrl_pkg.sv
// Shared types and default widths for the fork/join controller.
package fork_join_pkg;

  localparam int DUR_W_DEF = 8;
  localparam int NOW_W     = 16;

  typedef enum logic [1:0] {
    JOIN_ALL  = 2'd0,
    JOIN_ANY  = 2'd1,
    JOIN_NONE = 2'd2,
    JOIN_RSVD = 2'd3
  } join_mode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    DETACHED = 2'd2
  } fj_state_e;

endpackage

// File: rtl/fork_join_ctrl_task_timer.sv
// One worker timer: loads max(duration,1), pulses done in its last cycle,
// then drops busy. done_nxt predicts next cycle's pulse for the join logic.
module task_timer
  import fork_join_pkg::*;
#(
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DUR_W-1:0] duration,
  output logic             busy,
  output logic             done,
  output logic             done_nxt
);

  localparam logic [DUR_W-1:0] ONE = {{(DUR_W-1){1'b0}}, 1'b1};
  localparam logic [DUR_W-1:0] TWO = {{(DUR_W-2){1'b0}}, 2'b10};

  logic [DUR_W-1:0] cnt_r;
  logic [DUR_W-1:0] dur_eff_s;
  logic             busy_r;
  logic             done_r;
  logic             done_nxt_s;

  // Effective duration and next-cycle completion prediction.
  always_comb begin
    dur_eff_s  = (duration == '0) ? ONE : duration;
    done_nxt_s = 1'b0;
    if (load) begin
      done_nxt_s = (dur_eff_s == ONE);
    end else if (busy_r && !done_r) begin
      done_nxt_s = (cnt_r == TWO);
    end else begin
      done_nxt_s = 1'b0;
    end
  end

  // Countdown state; cnt_r holds the remaining cycles including the current one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (load) begin
      cnt_r  <= dur_eff_s;
      busy_r <= 1'b1;
      done_r <= done_nxt_s;
    end else if (busy_r) begin
      cnt_r  <= cnt_r - ONE;
      done_r <= done_nxt_s;
      if (done_r) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= 1'b1;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign done_nxt = done_nxt_s;

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join controller: one dispatch launches N_TASK timers and releases the
// parent on all-done, first-done or immediately, depending on the join mode.
module fork_join_ctrl
  import fork_join_pkg::*;
#(
  parameter int N_TASK = 2,
  parameter int DUR_W  = DUR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [1:0]              join_mode,
  input  logic [N_TASK*DUR_W-1:0] dur,
  output logic [N_TASK-1:0]       task_busy,
  output logic [N_TASK-1:0]       task_done,
  output logic                    parent_go,
  output logic [NOW_W-1:0]        now
);

  localparam logic [NOW_W-1:0] NOW_ONE = {{(NOW_W-1){1'b0}}, 1'b1};

  fj_state_e        state_r;
  join_mode_e       mode_r;
  join_mode_e       mode_s;
  logic             start_ready_r;
  logic             parent_go_r;
  logic [NOW_W-1:0] now_r;

  logic              accept_s;
  logic [N_TASK-1:0] busy_s;
  logic [N_TASK-1:0] done_s;
  logic [N_TASK-1:0] done_nxt_s;
  logic [N_TASK-1:0] outstanding_nxt_s;
  logic              drain_done_s;
  logic              wait_go_s;

  for (genvar i = 0; i < N_TASK; i++) begin : g_task
    task_timer #(.DUR_W(DUR_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept_s),
      .duration (dur[i*DUR_W +: DUR_W]),
      .busy     (busy_s[i]),
      .done     (done_s[i]),
      .done_nxt (done_nxt_s[i])
    );
  end

  // Join conditions; outputs are registered, so decisions look one cycle ahead.
  always_comb begin
    mode_s            = join_mode_e'(join_mode);
    accept_s          = start_valid && start_ready_r && (state_r == IDLE);
    outstanding_nxt_s = busy_s & ~done_s & ~done_nxt_s;
    drain_done_s      = ((busy_s & ~done_s) == '0);
    if (mode_r == JOIN_ANY) begin
      wait_go_s = |done_nxt_s;
    end else begin
      wait_go_s = (outstanding_nxt_s == '0);
    end
  end

  // Dispatch FSM with registered start_ready and parent_go.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      mode_r        <= JOIN_ALL;
      start_ready_r <= 1'b1;
      parent_go_r   <= 1'b0;
    end else begin
      parent_go_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mode_r        <= mode_s;
            start_ready_r <= 1'b0;
            case (mode_s)
              JOIN_NONE: begin
                parent_go_r <= 1'b1;
                state_r     <= DETACHED;
              end
              JOIN_ANY: begin
                parent_go_r <= |done_nxt_s;
                state_r     <= (|done_nxt_s) ? DETACHED : WAIT;
              end
              default: begin
                parent_go_r <= &done_nxt_s;
                state_r     <= (&done_nxt_s) ? DETACHED : WAIT;
              end
            endcase
          end else begin
            start_ready_r <= 1'b1;
          end
        end
        WAIT: begin
          if (drain_done_s) begin
            state_r       <= IDLE;
            start_ready_r <= 1'b1;
          end else if (wait_go_s) begin
            parent_go_r <= 1'b1;
            state_r     <= DETACHED;
          end else begin
            state_r <= WAIT;
          end
        end
        DETACHED: begin
          if (drain_done_s) begin
            state_r       <= IDLE;
            start_ready_r <= 1'b1;
          end else begin
            state_r <= DETACHED;
          end
        end
        default: begin
          state_r       <= IDLE;
          start_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Free-running cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      now_r <= '0;
    end else begin
      now_r <= now_r + NOW_ONE;
    end
  end

  assign start_ready = start_ready_r;
  assign task_busy   = busy_s;
  assign task_done   = done_s;
  assign parent_go   = parent_go_r;
  assign now         = now_r;

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Self-checking bench: directed and random dispatches against a timeline model.
module tb_fork_join_ctrl;

  localparam int N  = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_valid = 1'b0;
  logic [1:0]    join_mode = 2'd0;
  logic [N*DW-1:0] dur = '0;
  logic          start_ready;
  logic [N-1:0]  task_busy;
  logic [N-1:0]  task_done;
  logic          parent_go;
  logic [15:0]   now;

  fork_join_ctrl #(.N_TASK(N), .DUR_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .join_mode   (join_mode),
    .dur         (dur),
    .task_busy   (task_busy),
    .task_done   (task_done),
    .parent_go   (parent_go),
    .now         (now)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model of the current dispatch: accept cycle, effective durations, mode.
  bit          active = 1'b0;
  bit          acc = 1'b0;
  int          a_cyc = 0;
  int          mode_exp = 0;
  int          d_exp[N];
  logic [15:0] now_exp = 16'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int dmax();
    int m = 0;
    for (int i = 0; i < N; i++) if (d_exp[i] > m) m = d_exp[i];
    return m;
  endfunction

  function automatic int dmin();
    int m = 1 << 20;
    for (int i = 0; i < N; i++) if (d_exp[i] < m) m = d_exp[i];
    return m;
  endfunction

  function automatic bit exp_ready(input int c);
    return !active || (c > a_cyc + dmax());
  endfunction

  function automatic bit exp_go(input int c);
    int lat;
    if (mode_exp == 2) lat = 1;
    else if (mode_exp == 1) lat = dmin();
    else lat = dmax();
    return active && (c == a_cyc + lat);
  endfunction

  task automatic check_all();
    logic [N-1:0] eb, ed;
    for (int i = 0; i < N; i++) begin
      eb[i] = active && (cyc >= a_cyc + 1) && (cyc <= a_cyc + d_exp[i]);
      ed[i] = active && (cyc == a_cyc + d_exp[i]);
    end
    check_eq("start_ready", 32'(start_ready), 32'(exp_ready(cyc)));
    check_eq("task_busy",   32'(task_busy),   32'(eb));
    check_eq("task_done",   32'(task_done),   32'(ed));
    check_eq("parent_go",   32'(parent_go),   32'(exp_go(cyc)));
    check_eq("now",         32'(now),         32'(now_exp));
  endtask

  // Commit this cycle's inputs to the model, advance one cycle, check outputs.
  task automatic tick();
    acc = 1'b0;
    if (!rst_n) begin
      active  = 1'b0;
      now_exp = 16'd0;
    end else begin
      if (start_valid && exp_ready(cyc)) begin
        acc      = 1'b1;
        active   = 1'b1;
        a_cyc    = cyc;
        mode_exp = int'(join_mode);
        for (int i = 0; i < N; i++) begin
          d_exp[i] = int'(dur[i*DW +: DW]);
          if (d_exp[i] == 0) d_exp[i] = 1;
        end
      end
      now_exp = now_exp + 16'd1;
    end
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic set_req(input int mode, input int d0, input int d1);
    join_mode = mode[1:0];
    dur[DW-1:0]    = d0[DW-1:0];
    dur[2*DW-1:DW] = d1[DW-1:0];
  endtask

  task automatic dispatch(input int mode, input int d0, input int d1, input int run);
    set_req(mode, d0, d1);
    start_valid = 1'b1;
    tick();
    check_eq("accept_idle", 32'(acc), 32'd1);
    start_valid = 1'b0;
    repeat (run) tick();
  endtask

  initial begin
    int guard;
    d_exp[0] = 1;
    d_exp[1] = 1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    dispatch(2, 20, 30, 33);   // JOIN_NONE
    dispatch(1, 20, 30, 33);   // JOIN_ANY
    dispatch(0, 20, 30, 33);   // JOIN_ALL
    dispatch(1, 5, 5, 7);      // simultaneous finish, one parent_go
    dispatch(1, 0, 3, 5);      // zero duration completes in cycle 1
    dispatch(0, 4, 4, 6);
    dispatch(3, 2, 6, 8);      // reserved behaves as ALL
    dispatch(0, 0, 0, 3);

    // Request held while busy; accepted only when ready, with the new durations.
    dispatch(0, 10, 15, 3);
    set_req(1, 7, 2);
    start_valid = 1'b1;
    guard = 0;
    while (!acc && guard < 40) begin
      tick();
      guard++;
    end
    check_eq("held_accept", 32'(acc), 32'd1);
    start_valid = 1'b0;
    repeat (10) tick();

    // Reset in the middle of a JOIN_ALL run.
    dispatch(0, 20, 30, 9);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();

    // Random dispatches, holding the request until accepted.
    for (int n = 0; n < 60; n++) begin
      set_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
              int'($urandom_range(0, 12)));
      start_valid = 1'b1;
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 40) begin
        tick();
        guard++;
      end
      check_eq("rand_accept", 32'(acc), 32'd1);
      start_valid = 1'b0;
      repeat ($urandom_range(0, 6)) tick();
      if ($urandom_range(0, 14) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
